// File: rtl/qam_pkg.sv
// Shared QAM definitions: mode encodings, I/Q field positions within a symbol
// word, frame FSM state type, and a small helper for building symbol words.
package qam_pkg;

  localparam int unsigned QAM_W = 3;

  typedef enum logic [QAM_W-1:0] {
    QamBpsk = 3'd0,
    QamQpsk = 3'd1,
    Qam16   = 3'd2
  } qam_mode_e;

  // I occupies the upper half of a 32-bit symbol, Q the lower half
  localparam int unsigned I_MSB = 31;
  localparam int unsigned I_LSB = 16;
  localparam int unsigned Q_MSB = 15;
  localparam int unsigned Q_LSB = 0;

  typedef enum logic {
    StIdle,
    StInFrame
  } frame_state_e;

  function automatic logic [31:0] iq_pack(input logic [15:0] i_val, input logic [15:0] q_val);
    logic [31:0] w;
    w = '0;
    w[I_MSB:I_LSB] = i_val;
    w[Q_MSB:Q_LSB] = q_val;
    return w;
  endfunction

endpackage

// File: rtl/qam_sync_fifo.sv
// Synchronous FIFO holding symbol words together with their mode tag.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-low reset (clears pointers and level)
//   wr_en    push wr_data (ignored when full)
//   wr_data  entry to push
//   rd_en    pop head entry (ignored when empty)
//   rd_data  head entry (combinational)
//   level    current occupancy, 0..DEPTH
module qam_sync_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             wr_ok;
  logic             rd_ok;

  // Guard against pushes when full / pops when empty regardless of caller
  assign wr_ok = wr_en && (level_q != (AW + 1)'(DEPTH));
  assign rd_ok = rd_en && (level_q != '0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/qam_frame_buffer.sv
// Frame buffer between the QAM modulator and the DAC/DMA. Symbols are queued
// with the mode tag in effect when they were written; the read side groups
// words into frames of FRAME_LEN, flags the last word, and holds the mode
// tag of the frame's first word for the whole frame.
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   s_data/s_valid/s_ready input symbol stream
//   qam                    upstream mode, tagged onto each written word
//   m_data/m_valid/m_ready output symbol stream
//   m_last                 current m_data ends a frame
//   m_qam                  mode tag of the current frame
//   level                  FIFO occupancy
//   overflow               sticky: write attempted while not ready
module qam_frame_buffer
  import qam_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [QAM_W-1:0]       qam,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [QAM_W-1:0]       m_qam,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic [DATA_W+QAM_W-1:0] head;
  logic [QAM_W-1:0]        head_qam;
  logic                    wr_en;
  logic                    rd_en;

  frame_state_e      state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [QAM_W-1:0]  qam_lat_q;
  logic              overflow_q;

  assign s_ready = rst && (level != LW'(DEPTH));
  assign m_valid = rst && (level != '0);
  assign wr_en   = s_valid && s_ready;
  assign rd_en   = m_valid && m_ready;

  qam_sync_fifo #(
    .WIDTH (DATA_W + QAM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({qam, s_data}),
    .rd_en   (rd_en),
    .rd_data (head),
    .level   (level)
  );

  assign head_qam = head[DATA_W +: QAM_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      qam_lat_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (s_valid && !s_ready) overflow_q <= 1'b1;
      // An empty FIFO mid-frame simply waits: no read, state unchanged
      if (rd_en) begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StInFrame;
            fcnt_q    <= FCNT_W'(1);
            qam_lat_q <= head_qam;
          end
          StInFrame: begin
            if (fcnt_q == FCNT_LAST) begin
              state_q <= StIdle;
              fcnt_q  <= '0;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign m_data   = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last   = m_valid && (fcnt_q == FCNT_LAST);
  assign overflow = overflow_q;

  // Mid-frame the latched tag wins even when the FIFO has run dry
  always_comb begin
    m_qam = '0;
    if (rst) begin
      if (state_q == StInFrame) m_qam = qam_lat_q;
      else if (m_valid)         m_qam = head_qam;
    end
  end

endmodule

// File: tb/tb_qam_frame_buffer.sv
module tb_qam_frame_buffer;
  import qam_pkg::*;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int FL = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2:0]    qam = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [2:0]    m_qam;
  logic [LW-1:0] level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qam_frame_buffer #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .qam      (qam),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .m_qam    (m_qam),
    .level    (level),
    .overflow (overflow)
  );

  typedef struct packed {
    logic        sv;
    logic [31:0] sd;
    logic [2:0]  q;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [2:0]  eq;
    logic [4:0]  elv;
    logic        esr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_sr);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(1'b0));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(exp_sr));
    chk({tag, ".m_last"}, 32'(m_last), 32'(1'b0));
    chk({tag, ".m_qam"}, 32'(m_qam), 32'(3'd0));
    chk({tag, ".m_data"}, m_data, 32'h0);
    chk({tag, ".level"}, 32'(level), 32'd0);
  endtask

  logic [31:0] a1, a2, a3, a4, b1;

  initial begin
    a1 = iq_pack(16'h0001, 16'h0002);
    a2 = iq_pack(16'h0003, 16'h0004);
    a3 = iq_pack(16'h0005, 16'h0006);
    a4 = iq_pack(16'h0007, 16'h0008);
    b1 = iq_pack(16'h7fff, 16'h8001);

    //          sv  sd    q       mr    ev    ed    el    eq      lv     sr
    tbl[0]  = '{1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b1};
    tbl[1]  = '{1'b1, a1,    3'd1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b1};
    tbl[2]  = '{1'b0, 32'h0, 3'd0, 1'b1, 1'b1, a1,    1'b0, 3'd1, 5'd1, 1'b1};
    tbl[3]  = '{1'b1, a2,    3'd2, 1'b1, 1'b0, 32'h0, 1'b0, 3'd1, 5'd0, 1'b1};
    tbl[4]  = '{1'b1, a3,    3'd2, 1'b1, 1'b1, a2,    1'b0, 3'd1, 5'd1, 1'b1};
    tbl[5]  = '{1'b1, a4,    3'd0, 1'b1, 1'b1, a3,    1'b0, 3'd1, 5'd1, 1'b1};
    tbl[6]  = '{1'b0, 32'h0, 3'd0, 1'b1, 1'b1, a4,    1'b1, 3'd1, 5'd1, 1'b1};
    tbl[7]  = '{1'b1, b1,    3'd2, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b1};
    tbl[8]  = '{1'b0, 32'h0, 3'd0, 1'b0, 1'b1, b1,    1'b0, 3'd2, 5'd1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0, 3'd0, 1'b0, 1'b1, b1,    1'b0, 3'd2, 5'd1, 1'b1};
    tbl[10] = '{1'b0, 32'h0, 3'd0, 1'b1, 1'b1, b1,    1'b0, 3'd2, 5'd1, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd2, 5'd0, 1'b1};

    // Reset values while rst is held low, with a write attempt present
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h1234_5678;
    tick();
    tick();
    check_idle_outputs("reset", 1'b0);
    chk("reset.overflow", 32'(overflow), 32'(1'b0));
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("release.s_ready", 32'(s_ready), 32'(1'b1));

    // Table: single-word latency, frame of 4 with mode change, hold under stall
    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      qam     = tbl[i].q;
      m_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.m_data", i), m_data, tbl[i].ed);
      chk($sformatf("vec%0d.m_last", i), 32'(m_last), 32'(tbl[i].el));
      chk($sformatf("vec%0d.m_qam", i), 32'(m_qam), 32'(tbl[i].eq));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].elv));
      chk($sformatf("vec%0d.s_ready", i), 32'(s_ready), 32'(tbl[i].esr));
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Fill to full, then one more attempt sets overflow
    do_reset();
    qam = 3'(QamQpsk);
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data = 32'(i);
      tick();
    end
    chk("full.level", 32'(level), 32'(DEPTH));
    chk("full.s_ready", 32'(s_ready), 32'(1'b0));
    chk("full.overflow_pre", 32'(overflow), 32'(1'b0));
    s_data = 32'hbad0_0bad;
    tick();
    s_valid = 1'b0;
    chk("full.overflow", 32'(overflow), 32'(1'b1));
    chk("full.level_after", 32'(level), 32'(DEPTH));

    // Full with read and write in the same cycle: read only
    s_valid = 1'b1;
    s_data = 32'hdead_beef;
    m_ready = 1'b1;
    #1;
    chk("fullrw.m_data", m_data, 32'd0);
    tick();
    s_valid = 1'b0;
    chk("fullrw.level", 32'(level), 32'(DEPTH - 1));
    chk("fullrw.s_ready", 32'(s_ready), 32'(1'b1));
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain%0d.m_data", i), m_data, 32'(i));
      chk($sformatf("drain%0d.m_last", i), 32'(m_last), 32'(((i + 1) % FL) == 0));
      tick();
    end
    m_ready = 1'b0;
    chk("drain.level", 32'(level), 32'd0);
    chk("drain.m_valid", 32'(m_valid), 32'(1'b0));
    chk("drain.overflow_sticky", 32'(overflow), 32'(1'b1));

    // 8 words, mode 1 for words 0-1 then mode 2; two frames of 4
    do_reset();
    chk("frames.overflow_cleared", 32'(overflow), 32'(1'b0));
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data = 32'h100 + 32'(i);
      qam = (i < 2) ? 3'(QamQpsk) : 3'(Qam16);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("frames%0d.m_data", k), m_data, 32'h100 + 32'(k));
      chk($sformatf("frames%0d.m_last", k), 32'(m_last), 32'((k % FL) == FL - 1));
      chk($sformatf("frames%0d.m_qam", k), 32'(m_qam), (k < 4) ? 32'd1 : 32'd2);
      tick();
    end
    m_ready = 1'b0;
    chk("frames.level", 32'(level), 32'd0);

    // Reset after two reads of a frame discards data and restarts framing
    do_reset();
    qam = 3'(QamQpsk);
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data = 32'h200 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("midrst%0d.m_data", k), m_data, 32'h200 + 32'(k));
      tick();
    end
    rst = 1'b0;
    s_valid = 1'b1;
    tick();
    check_idle_outputs("midrst.in_reset", 1'b0);
    chk("midrst.overflow", 32'(overflow), 32'(1'b0));
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    check_idle_outputs("midrst.released", 1'b1);
    qam = 3'(Qam16);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = 32'h300 + 32'(i);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("restart%0d.m_data", k), m_data, 32'h300 + 32'(k));
      chk($sformatf("restart%0d.m_last", k), 32'(m_last), 32'(k == FL - 1));
      chk($sformatf("restart%0d.m_qam", k), 32'(m_qam), 32'd2);
      tick();
    end
    m_ready = 1'b0;
    chk("restart.level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
